// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter: grants one of NREQ writeback sources per cycle and registers the write into the bank.
// Optional build macro WRARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module regfile_wr_arbiter #(
    parameter int W    = 16,
    parameter int NREQ = 4,
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*AW-1:0]   i_req_addr,
    input  logic [NREQ*W-1:0]    i_req_data,
    input  logic                 i_hold,
    output logic [NREQ-1:0]      o_gnt,
    output logic [NREG-1:0]      o_chosen,
    output logic                 o_w_en,
    output logic [W-1:0]         o_w_data,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW:0]     NREG_LIMIT = (AW+1)'(NREG);
    localparam logic [NREG-1:0] ONE_HOT_0  = NREG'(1);

    logic            w_found;
    logic [PW-1:0]   w_winner;
    logic [AW-1:0]   w_sel_addr;
    logic [W-1:0]    w_sel_data;
    logic            w_grant;
    logic            w_addr_ok;
    logic            w_x_seen;

    logic            r_w_en;
    logic [NREG-1:0] r_chosen;
    logic [W-1:0]    r_w_data;
    logic            r_err;

`ifdef WRARB_FIXED_PRIO_EN
    // Scanning downward lets the lowest set index overwrite any higher one.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            if (i_req[k]) begin
                w_found    = 1'b1;
                w_winner   = PW'(k);
                w_sel_addr = i_req_addr[k*AW +: AW];
                w_sel_data = i_req_data[k*W +: W];
            end
        end
    end
`else
    logic [PW-1:0] r_ptr;

    // Outer loop walks priority order from r_ptr; inner loop keeps every select index constant.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!w_found && i_req[k] &&
                    ((int'(r_ptr) + i == k) || (int'(r_ptr) + i == k + NREQ))) begin
                    w_found    = 1'b1;
                    w_winner   = PW'(k);
                    w_sel_addr = i_req_addr[k*AW +: AW];
                    w_sel_data = i_req_data[k*W +: W];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_winner == PW'(NREQ-1)) ? '0 : w_winner + PW'(1);
        end
    end
`endif

    assign w_grant   = i_rst_n && !i_hold && w_found;
    assign w_addr_ok = ({1'b0, w_sel_addr} < NREG_LIMIT);

`ifdef SYNTHESIS
    assign w_x_seen = 1'b0;
`else
    assign w_x_seen = $isunknown(i_req) || $isunknown(i_hold);
`endif

    always_comb begin
        o_gnt = '0;
        if (w_grant) begin
            o_gnt[w_winner] = 1'b1;
        end
    end

    // Out-of-range grants still release the requester but never reach the bank.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_w_en   <= 1'b0;
            r_chosen <= '0;
            r_w_data <= '0;
        end else if (w_grant && w_addr_ok) begin
            r_w_en   <= 1'b1;
            r_chosen <= ONE_HOT_0 << w_sel_addr;
            r_w_data <= w_sel_data;
        end else begin
            r_w_en   <= 1'b0;
            r_chosen <= '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if ((w_grant && !w_addr_ok) || w_x_seen) begin
            r_err <= 1'b1;
        end
    end

    assign o_chosen = r_chosen;
    assign o_w_en   = r_w_en;
    assign o_w_data = r_w_data;
    assign o_busy   = (|i_req) || r_w_en;
    assign o_err    = r_err;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: two instances (NREG=8 and NREG=6) share stimulus against a queue-free reference model.
// Honours WRARB_FIXED_PRIO_EN the same way the design does.
module tb_regfile_wr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN;
    logic        hold;
    logic [3:0]  req;
    logic [11:0] reqAddr;
    logic [63:0] reqData;

    logic [3:0]  gnt8, gnt6;
    logic [7:0]  chosen8;
    logic [5:0]  chosen6;
    logic        wEn8, wEn6, busy8, busy6, err8, err6;
    logic [15:0] wData8, wData6;

    regfile_wr_arbiter #(.W(16), .NREQ(4), .NREG(8), .AW(3)) dut8 (
        .i_clk(clk), .i_rst_n(rstN), .i_req(req), .i_req_addr(reqAddr),
        .i_req_data(reqData), .i_hold(hold), .o_gnt(gnt8), .o_chosen(chosen8),
        .o_w_en(wEn8), .o_w_data(wData8), .o_busy(busy8), .o_err(err8)
    );

    regfile_wr_arbiter #(.W(16), .NREQ(4), .NREG(6), .AW(3)) dut6 (
        .i_clk(clk), .i_rst_n(rstN), .i_req(req), .i_req_addr(reqAddr),
        .i_req_data(reqData), .i_hold(hold), .o_gnt(gnt6), .o_chosen(chosen6),
        .o_w_en(wEn6), .o_w_data(wData6), .o_busy(busy6), .o_err(err6)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference state; index 0 models the NREG=8 instance, index 1 the NREG=6 instance.
    int          mPtr;
    logic        mWEn    [2];
    logic [7:0]  mChosen [2];
    logic [15:0] mWData  [2];
    logic        mErr    [2];
    int          nreg    [2] = '{8, 6};
    logic [3:0]  eGnt;

    logic [3:0]  sGnt, sGnt6;
    logic        sWEn, sWEn6, sErr, sErr6;
    logic [7:0]  sChosen;
    logic [15:0] sWData;

    localparam logic [3:0] T3_SEQ [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pickWinner(input logic [3:0] r);
`ifdef WRARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) begin
            if (r[i]) return i;
        end
`else
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (mPtr + i) % 4;
            if (r[k]) return k;
        end
`endif
        return -1;
    endfunction

    task automatic modelReset();
        mPtr = 0;
        for (int d = 0; d < 2; d++) begin
            mWEn[d]    = 1'b0;
            mChosen[d] = '0;
            mWData[d]  = '0;
            mErr[d]    = 1'b0;
        end
    endtask

    task automatic setReq(input int k, input logic [2:0] a, input logic [15:0] dat);
        reqAddr[k*3 +: 3]   = a;
        reqData[k*16 +: 16] = dat;
    endtask

    // One full cycle: drive on the falling edge, check mid-cycle, advance the model after the rising edge.
    task automatic applyStimulus(input logic rs, input logic [3:0] r, input logic h);
        int win;
        int a;
        @(negedge clk);
        rstN = rs;
        req  = r;
        hold = h;
        if (!rs) modelReset();
        #1;
        win  = (rs && !h) ? pickWinner(r) : -1;
        eGnt = '0;
        if (win >= 0) eGnt[win] = 1'b1;

        sGnt = gnt8; sGnt6 = gnt6; sWEn = wEn8; sWEn6 = wEn6;
        sErr = err8; sErr6 = err6; sChosen = chosen8; sWData = wData8;

        checkOutput("gnt8",    64'(gnt8),    64'(eGnt));
        checkOutput("gnt6",    64'(gnt6),    64'(eGnt));
        checkOutput("wen8",    64'(wEn8),    64'(mWEn[0]));
        checkOutput("wen6",    64'(wEn6),    64'(mWEn[1]));
        checkOutput("chosen8", 64'(chosen8), 64'(mChosen[0]));
        checkOutput("chosen6", 64'(chosen6), 64'(mChosen[1]));
        checkOutput("wdata8",  64'(wData8),  64'(mWData[0]));
        checkOutput("wdata6",  64'(wData6),  64'(mWData[1]));
        checkOutput("err8",    64'(err8),    64'(mErr[0]));
        checkOutput("err6",    64'(err6),    64'(mErr[1]));
        checkOutput("busy8",   64'(busy8),   64'((|r) || mWEn[0]));
        checkOutput("busy6",   64'(busy6),   64'((|r) || mWEn[1]));

        @(posedge clk);
        #1;
        if (rs && win >= 0) begin
            a = int'(reqAddr[win*3 +: 3]);
            for (int d = 0; d < 2; d++) begin
                if (a < nreg[d]) begin
                    mWEn[d]    = 1'b1;
                    mChosen[d] = 8'(1 << a);
                    mWData[d]  = reqData[win*16 +: 16];
                end else begin
                    mWEn[d]    = 1'b0;
                    mChosen[d] = '0;
                    mErr[d]    = 1'b1;
                end
            end
            mPtr = (win + 1) % 4;
        end else begin
            for (int d = 0; d < 2; d++) begin
                mWEn[d]    = 1'b0;
                mChosen[d] = '0;
            end
        end
    endtask

    initial begin
        logic [3:0] pend;
        logic       rs, h;

        rstN = 1'b0; hold = 1'b0; req = '0; reqAddr = '0; reqData = '0;
        modelReset();
        for (int k = 0; k < 4; k++) setReq(k, 3'(k + 1), 16'(16'h1000 + k));

        applyStimulus(1'b0, 4'hF, 1'b0);
        checkOutput("t1_gnt",    64'(sGnt),    64'h0);
        checkOutput("t1_wen",    64'(sWEn),    64'h0);
        checkOutput("t1_chosen", 64'(sChosen), 64'h0);
        checkOutput("t1_wdata",  64'(sWData),  64'h0);
        checkOutput("t1_err",    64'(sErr),    64'h0);

`ifndef WRARB_FIXED_PRIO_EN
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, 4'hF, 1'b0);
            checkOutput("t3_gnt", 64'(sGnt), 64'(T3_SEQ[c]));
            if (c > 0) checkOutput("t3_wen", 64'(sWEn), 64'h1);
        end

        setReq(0, 3'd3, 16'hBEEF);
        applyStimulus(1'b1, 4'b0001, 1'b0);
        checkOutput("t2_gnt",    64'(sGnt),    64'h1);
        checkOutput("t3_wen",    64'(sWEn),    64'h1);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("t2_wen",    64'(sWEn),    64'h1);
        checkOutput("t2_chosen", 64'(sChosen), 64'h08);
        checkOutput("t2_wdata",  64'(sWData),  64'hBEEF);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("t2_wen_off", 64'(sWEn),   64'h0);

        setReq(1, 3'd5, 16'h1111);
        setReq(3, 3'd6, 16'h3333);
        applyStimulus(1'b1, 4'b0010, 1'b0);
        checkOutput("t4_pre_gnt", 64'(sGnt), 64'b0010);
        applyStimulus(1'b1, 4'b1010, 1'b0);
        checkOutput("t4_gnt_a",   64'(sGnt), 64'b1000);
        applyStimulus(1'b1, 4'b0010, 1'b0);
        checkOutput("t4_gnt_b",   64'(sGnt),    64'b0010);
        checkOutput("t4_wdata_a", 64'(sWData),  64'h3333);
        checkOutput("t4_chos_a",  64'(sChosen), 64'h40);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("t4_wdata_b", 64'(sWData),  64'h1111);
        checkOutput("t4_chos_b",  64'(sChosen), 64'h20);

        applyStimulus(1'b1, 4'b0000, 1'b0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 4'b0100, 1'b1);
            checkOutput("t5_hold_gnt", 64'(sGnt), 64'h0);
            checkOutput("t5_hold_wen", 64'(sWEn), 64'h0);
        end
        applyStimulus(1'b1, 4'b0100, 1'b0);
        checkOutput("t5_gnt", 64'(sGnt), 64'b0100);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("t5_wen", 64'(sWEn), 64'h1);
`else
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 4'b1010, 1'b0);
            checkOutput("fp_gnt", 64'(sGnt), 64'b0010);
        end
        applyStimulus(1'b1, 4'b0000, 1'b0);
`endif

        setReq(0, 3'd7, 16'hCAFE);
        applyStimulus(1'b1, 4'b0001, 1'b0);
        checkOutput("t6_gnt6", 64'(sGnt6), 64'h1);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("t6_wen6", 64'(sWEn6), 64'h0);
        checkOutput("t6_err6", 64'(sErr6), 64'h1);
        checkOutput("t6_wen8", 64'(sWEn),  64'h1);
        checkOutput("t6_chos8", 64'(sChosen), 64'h80);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 4'b0000, 1'b0);
            checkOutput("t6_err6_sticky", 64'(sErr6), 64'h1);
        end
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("t6_err6_clr", 64'(sErr6), 64'h0);

        pend = '0;
        for (int c = 0; c < 1500; c++) begin
            rs = ($urandom_range(0, 299) != 0);
            if (!rs) begin
                pend = '0;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (!pend[k] && $urandom_range(0, 2) != 0) begin
                        pend[k] = 1'b1;
                        setReq(k, 3'($urandom_range(0, 7)), 16'($urandom));
                    end
                end
            end
            h = ($urandom_range(0, 5) == 0);
            applyStimulus(rs, pend, h);
            pend = pend & ~eGnt;
        end

        applyStimulus(1'b0, 4'b0000, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
